mem_dma: RTL and testbench

- Word-granular DMA engine that acts as the bus initiator toward the data memory.
- Drives the memory's rd/wr/addr/wdata port and samples its combinational rdata.
- Copies a block of words from a source region to a destination region (COPY), or fills a region with a constant (FILL).
- Sits beside the CPU datapath and owns the memory port only while busy; the port mux is external.

---
 rtl/mem_dma_if.sv | 30 +++
 rtl/mem_dma.sv | 133 +++++++++++++
 tb/tb_mem_dma.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dma_if.sv
// Request/status and memory-port bundle between the DMA engine and its surroundings.
// The master side is the DMA engine; the slave side is the controller plus memory.
interface mem_dma_if #(
  parameter int RAM_SIZE_BIT = 8
);
  logic                  start;
  logic                  mode;
  logic [31:0]           src_addr;
  logic [31:0]           dst_addr;
  logic [RAM_SIZE_BIT:0] len;
  logic [31:0]           fill_val;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport master (
    input  start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
    output busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output start, mode, src_addr, dst_addr, len, fill_val, mem_rdata,
    input  busy, done, err, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_dma.sv
// Word-granular DMA engine: COPY a block of words or FILL a region with a constant.
// Owns the memory port only while busy; all memory outputs are zero when idle.
module mem_dma #(
  parameter int RAM_SIZE     = 256,
  parameter int RAM_SIZE_BIT = 8
) (
  input logic       clk,
  input logic       reset,
  mem_dma_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  localparam logic [RAM_SIZE_BIT:0] LEN_ONE = 1;

  state_t                state, state_next;
  logic                  mode_q;
  logic [31:0]           src_q;
  logic [31:0]           dst_q;
  logic [RAM_SIZE_BIT:0] rem_q;
  logic [31:0]           fill_q;
  logic [31:0]           data_q;
  logic                  err_q;

  logic                  misaligned;
  logic                  out_of_range;
  logic                  reject;
  logic [32:0]           src_end;
  logic [32:0]           dst_end;

  logic                  busy_c;
  logic                  done_c;
  logic                  rd_c;
  logic                  wr_c;
  logic [31:0]           addr_c;
  logic [31:0]           wdata_c;

  // Word-index end points are formed in 33 bits so a huge address plus len cannot wrap.
  assign src_end      = 33'(bus.src_addr[31:2]) + 33'(bus.len);
  assign dst_end      = 33'(bus.dst_addr[31:2]) + 33'(bus.len);
  assign misaligned   = (bus.dst_addr[1:0] != 2'b00) ||
                        (!bus.mode && (bus.src_addr[1:0] != 2'b00));
  assign out_of_range = (dst_end > 33'(RAM_SIZE)) ||
                        (!bus.mode && (src_end > 33'(RAM_SIZE)));
  assign reject       = misaligned || out_of_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    rd_c       = 1'b0;
    wr_c       = 1'b0;
    addr_c     = 32'h0;
    wdata_c    = 32'h0;
    case (state)
      IDLE: begin
        if (bus.start && !reject) begin
          if (bus.len == '0)  state_next = FIN;
          else if (bus.mode)  state_next = WR;
          else                state_next = RD;
        end
      end
      RD: begin
        busy_c     = 1'b1;
        rd_c       = 1'b1;
        addr_c     = src_q;
        state_next = WR;
      end
      WR: begin
        busy_c  = 1'b1;
        wr_c    = 1'b1;
        addr_c  = dst_q;
        wdata_c = mode_q ? fill_q : data_q;
        if (rem_q == LEN_ONE) state_next = FIN;
        else if (mode_q)      state_next = WR;
        else                  state_next = RD;
      end
      FIN: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latching, read-data capture and pointer advance; err is a registered pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
      src_q  <= 32'h0;
      dst_q  <= 32'h0;
      rem_q  <= '0;
      fill_q <= 32'h0;
      data_q <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q <= bus.mode;
            src_q  <= bus.src_addr;
            dst_q  <= bus.dst_addr;
            rem_q  <= bus.len;
            fill_q <= bus.fill_val;
            err_q  <= reject;
          end
        end
        RD: data_q <= bus.mem_rdata;
        WR: begin
          src_q <= src_q + 32'd4;
          dst_q <= dst_q + 32'd4;
          rem_q <= rem_q - LEN_ONE;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.err       = err_q;
  assign bus.mem_rd    = rd_c;
  assign bus.mem_wr    = wr_c;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = wdata_c;

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: a 256-word memory model plus a word-by-word
// reference of each transfer (bus trace, timing, final memory image).
module tb_mem_dma;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_dma_if #(.RAM_SIZE_BIT(8)) bus ();

  mem_dma #(.RAM_SIZE(256), .RAM_SIZE_BIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_data = 32'h0;

  int compared   = 0;
  int mismatched = 0;

  // Memory with combinational read; the bench preloads words through the same write port.
  assign bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (pre_we)          mem[pre_idx] <= pre_data;
    else if (bus.mem_wr) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end

  task automatic check_output(input string tag, input logic [71:0] observed,
                              input logic [71:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = 8'(idx);
    pre_data = data;
    ref_mem[idx] = data;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    check_output(tag, diffs, 0);
  endtask

  // Issue one request, watch the bus, and compare against the reference of the same request.
  task automatic run_xfer(input string tag, input logic m, input logic [31:0] s,
                          input logic [31:0] d, input int n, input logic [31:0] f,
                          input int decoy_at);
    logic [65:0] exp_q[$];
    logic [65:0] obs_q[$];
    logic [31:0] w;
    bit rej;
    int exp_done, window, lim;
    int done_cnt = 0, err_cnt = 0, busy_cnt = 0, first_done = 0, first_err = 0, viol = 0;

    rej = (d[1:0] != 2'b00) || (!m && (s[1:0] != 2'b00)) ||
          (longint'(d >> 2) + n > 256) || (!m && (longint'(s >> 2) + n > 256));
    if (!rej) begin
      for (int i = 0; i < n; i++) begin
        if (m) begin
          exp_q.push_back({2'b01, d + 32'(4 * i), f});
          ref_mem[(d >> 2) + i] = f;
        end else begin
          w = ref_mem[(s >> 2) + i];
          exp_q.push_back({2'b10, s + 32'(4 * i), 32'h0});
          exp_q.push_back({2'b01, d + 32'(4 * i), w});
          ref_mem[(d >> 2) + i] = w;
        end
      end
    end
    exp_done = rej ? 0 : exp_q.size() + 1;
    window   = exp_q.size() + 4;

    @(negedge clk);
    bus.start    = 1'b1;
    bus.mode     = m;
    bus.src_addr = s;
    bus.dst_addr = d;
    bus.len      = 9'(n);
    bus.fill_val = f;
    for (int k = 1; k <= window; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (decoy_at != 0 && k == decoy_at) begin
        bus.start    = 1'b1;
        bus.mode     = ~m;
        bus.src_addr = 32'h0;
        bus.dst_addr = 32'h0;
        bus.len      = 9'd1;
        bus.fill_val = 32'hBAD0BAD0;
      end else if (decoy_at != 0 && k == decoy_at + 1) begin
        bus.start = 1'b0;
      end
      if (bus.mem_rd && bus.mem_wr) viol++;
      if (!bus.mem_rd && !bus.mem_wr && (bus.mem_addr != 32'h0 || bus.mem_wdata != 32'h0)) viol++;
      if (bus.done && bus.err) viol++;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; if (first_done == 0) first_done = k; end
      if (bus.err)  begin err_cnt++;  if (first_err == 0)  first_err = k;  end
      if (bus.mem_rd)      obs_q.push_back({2'b10, bus.mem_addr, 32'h0});
      else if (bus.mem_wr) obs_q.push_back({2'b01, bus.mem_addr, bus.mem_wdata});
    end

    check_output({tag, "_err_cycle"},  first_err,  rej ? 1 : 0);
    check_output({tag, "_err_count"},  err_cnt,    rej ? 1 : 0);
    check_output({tag, "_done_cycle"}, first_done, exp_done);
    check_output({tag, "_done_count"}, done_cnt,   rej ? 0 : 1);
    check_output({tag, "_busy_cycles"}, busy_cnt,  exp_q.size());
    check_output({tag, "_bus_ops"},    obs_q.size(), exp_q.size());
    lim = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      check_output($sformatf("%s_op%0d", tag, i), obs_q[i], exp_q[i]);
    check_output({tag, "_invariants"}, viol, 0);
    check_mem({tag, "_mem"});
  endtask

  initial begin
    logic [31:0] fv;
    logic [31:0] sa, da;
    int viol_r;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.mode     = 1'b0;
    bus.src_addr = 32'h0;
    bus.dst_addr = 32'h0;
    bus.len      = 9'd0;
    bus.fill_val = 32'h0;
    repeat (2) @(negedge clk);
    check_output("reset_outputs",
                 {bus.busy, bus.done, bus.err, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata},
                 72'h0);
    reset = 1'b0;

    for (int i = 0; i < 256; i++) poke(i, $urandom);
    poke(0, 32'hA0A0_0001);
    poke(1, 32'hB0B0_0002);
    poke(2, 32'hC0C0_0003);
    poke(3, 32'hD0D0_0004);
    check_mem("preload");
    $display("[TB] memory preloaded");

    run_xfer("copy4", 1'b0, 32'h000, 32'h100, 4, 32'h0, 0);
    check_output("copy4_w64", mem[64], 32'hA0A0_0001);
    check_output("copy4_w65", mem[65], 32'hB0B0_0002);
    check_output("copy4_w66", mem[66], 32'hC0C0_0003);
    check_output("copy4_w67", mem[67], 32'hD0D0_0004);

    run_xfer("fill_top", 1'b1, 32'h0, 32'h3F0, 4, 32'hDEADBEEF, 0);
    for (int i = 252; i < 256; i++)
      check_output($sformatf("fill_top_w%0d", i), mem[i], 32'hDEADBEEF);

    run_xfer("fill_oor",   1'b1, 32'h0, 32'h3F4, 4, 32'h1234_5678, 0);
    run_xfer("fill_edge",  1'b1, 32'h0, 32'h3F4, 3, 32'h1234_5678, 0);
    run_xfer("copy_mis",   1'b0, 32'h002, 32'h200, 2, 32'h0, 0);
    run_xfer("dst_mis",    1'b1, 32'h0, 32'h201, 2, 32'h5, 0);
    run_xfer("copy_oor",   1'b0, 32'h3FC, 32'h000, 2, 32'h0, 0);
    run_xfer("huge_addr",  1'b1, 32'h0, 32'hFFFF_FFFC, 1, 32'h7, 0);
    run_xfer("len0",       1'b0, 32'h010, 32'h020, 0, 32'h0, 0);
    run_xfer("fill_all",   1'b1, 32'h0, 32'h000, 256, $urandom, 0);
    run_xfer("copy_decoy", 1'b0, 32'h040, 32'h300, 4, 32'h0, 3);

    poke(0, 32'h5EED_C0DE);
    run_xfer("overlap", 1'b0, 32'h000, 32'h004, 3, 32'h0, 0);
    check_output("overlap_w3", mem[3], 32'h5EED_C0DE);

    // Reset in the third write of an 8-word fill: earlier words stay, the rest is abandoned.
    fv = 32'h5A5A_1234;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.mode     = 1'b1;
    bus.src_addr = 32'h0;
    bus.dst_addr = 32'h200;
    bus.len      = 9'd8;
    bus.fill_val = fv;
    viol_r = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (!bus.mem_wr || bus.mem_addr != 32'h200 + 32'(4 * (k - 1))) viol_r++;
    end
    check_output("rst_pre_writes", viol_r, 0);
    reset = 1'b1;
    #1;
    check_output("rst_async_outputs",
                 {bus.busy, bus.done, bus.err, bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata},
                 72'h0);
    @(negedge clk);
    reset = 1'b0;
    ref_mem[128] = fv;
    ref_mem[129] = fv;
    check_mem("rst_mem");
    run_xfer("after_rst", 1'b0, 32'h200, 32'h300, 2, 32'h0, 0);

    for (int t = 0; t < 25; t++) begin
      sa = 32'($urandom_range(0, 255)) << 2;
      da = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) sa[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) da[1:0] = 2'($urandom_range(1, 3));
      run_xfer($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sa, da,
               $urandom_range(0, 24), $urandom, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
